// File: rtl/y86_pkg.sv
// y86_pkg -- shared Y86-64 icode/length constants and fetch-state encoding.
// Rev 1.0
`default_nettype none

package y86_pkg;

  localparam int MAX_LEN = 10;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] LEN_HALT    = 4'd1;
  localparam logic [3:0] LEN_NOP     = 4'd1;
  localparam logic [3:0] LEN_RRMOVQ  = 4'd2;
  localparam logic [3:0] LEN_IRMOVQ  = 4'd10;
  localparam logic [3:0] LEN_RMMOVQ  = 4'd10;
  localparam logic [3:0] LEN_MRMOVQ  = 4'd10;
  localparam logic [3:0] LEN_OPQ     = 4'd2;
  localparam logic [3:0] LEN_JXX     = 4'd9;
  localparam logic [3:0] LEN_CALL    = 4'd9;
  localparam logic [3:0] LEN_RET     = 4'd1;
  localparam logic [3:0] LEN_PUSHQ   = 4'd2;
  localparam logic [3:0] LEN_POPQ    = 4'd2;
  localparam logic [3:0] LEN_INVALID = 4'd1;

  typedef enum logic [2:0] {
    FS_IDLE = 3'd0,
    FS_RD0  = 3'd1,
    FS_LEN  = 3'd2,
    FS_RDN  = 3'd3,
    FS_DONE = 3'd4
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/y86_len_decode.sv
// y86_len_decode -- combinational icode to instruction-length decoder.
// Rev 1.0
`default_nettype none

import y86_pkg::*;

module y86_len_decode (
  input  logic [3:0] icode_i,
  output logic [3:0] len_o,
  output logic       invalid_o
);

  always_comb begin
    len_o     = LEN_INVALID;
    invalid_o = 1'b0;
    case (icode_i)
      IHALT:   len_o = LEN_HALT;
      INOP:    len_o = LEN_NOP;
      IRRMOVQ: len_o = LEN_RRMOVQ;
      IIRMOVQ: len_o = LEN_IRMOVQ;
      IRMMOVQ: len_o = LEN_RMMOVQ;
      IMRMOVQ: len_o = LEN_MRMOVQ;
      IOPQ:    len_o = LEN_OPQ;
      IJXX:    len_o = LEN_JXX;
      ICALL:   len_o = LEN_CALL;
      IRET:    len_o = LEN_RET;
      IPUSHQ:  len_o = LEN_PUSHQ;
      IPOPQ:   len_o = LEN_POPQ;
      default: begin
        len_o     = LEN_INVALID;
        invalid_o = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// fetch_sequencer -- byte-serial Y86-64 instruction fetch with valid/ready output.
// Rev 1.0
`default_nettype none

import y86_pkg::*;

module fetch_sequencer #(
  parameter logic [63:0] MEM_LAST_ADDR = 64'd200,
  parameter int          MAX_LEN       = y86_pkg::MAX_LEN
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [63:0]            pc_in,
  input  logic                   pc_valid,
  output logic                   pc_ready,
  output logic                   mem_rd_en,
  output logic [63:0]            mem_addr,
  input  logic [7:0]             mem_rdata,
  output logic [8*MAX_LEN-1:0]   inst_bytes,
  output logic [3:0]             inst_len,
  output logic [63:0]            valP,
  output logic                   imem_error,
  output logic                   instr_invalid,
  output logic                   inst_valid,
  input  logic                   inst_ready
);

  fetch_state_e             state_q, state_d;
  logic [63:0]              pc_q, pc_d;
  logic [8*MAX_LEN-1:0]     bytes_q, bytes_d;
  logic [3:0]               len_q, len_d;
  logic [3:0]               idx_q, idx_d;
  logic                     err_q, err_d;
  logic                     inv_q, inv_d;

  logic [3:0]               w_dec_len;
  logic                     w_dec_inv;
  logic [3:0]               w_issue_k;
  logic [64:0]              w_addr_sum;
  logic                     w_addr_err;
  logic                     w_want_issue;
  logic                     w_issue;

  y86_len_decode u_len_decode (
    .icode_i   (mem_rdata[7:4]),
    .len_o     (w_dec_len),
    .invalid_o (w_dec_inv)
  );

  // Byte index about to be requested; idx_q is the byte arriving this cycle.
  always_comb begin
    w_want_issue = 1'b0;
    w_issue_k    = idx_q + 4'd1;
    case (state_q)
      FS_RD0: begin
        w_issue_k    = 4'd0;
        w_want_issue = 1'b1;
      end
      FS_LEN: begin
        w_issue_k    = 4'd1;
        w_want_issue = (w_dec_len != 4'd1);
      end
      FS_RDN:  w_want_issue = (idx_q != (len_q - 4'd1));
      default: w_want_issue = 1'b0;
    endcase
  end

  // 65-bit sum so a wrap past 2^64 is reported as out of range.
  assign w_addr_sum = {1'b0, pc_q} + {61'd0, w_issue_k};
  assign w_addr_err = (w_addr_sum > {1'b0, MEM_LAST_ADDR});
  assign w_issue    = w_want_issue && !w_addr_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FS_IDLE;
      pc_q    <= '0;
      bytes_q <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bytes_q <= bytes_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      inv_q   <= inv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    bytes_d = bytes_q;
    len_d   = len_q;
    idx_d   = idx_q;
    err_d   = err_q;
    inv_d   = inv_q;
    case (state_q)
      FS_IDLE: begin
        if (pc_valid) begin
          pc_d    = pc_in;
          bytes_d = '0;
          len_d   = '0;
          idx_d   = '0;
          err_d   = 1'b0;
          inv_d   = 1'b0;
          state_d = FS_RD0;
        end
      end
      FS_RD0: begin
        if (w_addr_err) begin
          err_d   = 1'b1;
          state_d = FS_DONE;
        end else begin
          state_d = FS_LEN;
        end
      end
      FS_LEN: begin
        bytes_d[7:0] = mem_rdata;
        len_d        = w_dec_len;
        inv_d        = w_dec_inv;
        idx_d        = 4'd1;
        if (!w_want_issue) begin
          state_d = FS_DONE;
        end else if (w_addr_err) begin
          err_d   = 1'b1;
          state_d = FS_DONE;
        end else begin
          state_d = FS_RDN;
        end
      end
      FS_RDN: begin
        for (int k = 0; k < MAX_LEN; k++) begin
          if (idx_q == 4'(k)) begin
            bytes_d[8*k +: 8] = mem_rdata;
          end
        end
        idx_d = idx_q + 4'd1;
        if (!w_want_issue) begin
          state_d = FS_DONE;
        end else if (w_addr_err) begin
          err_d   = 1'b1;
          state_d = FS_DONE;
        end
      end
      FS_DONE: begin
        if (inst_ready) begin
          err_d = 1'b0;
          inv_d = 1'b0;
          if (pc_valid) begin
            pc_d    = pc_in;
            bytes_d = '0;
            len_d   = '0;
            idx_d   = '0;
            state_d = FS_RD0;
          end else begin
            state_d = FS_IDLE;
          end
        end
      end
      default: state_d = FS_IDLE;
    endcase
  end

  always_comb begin
    pc_ready      = !reset && ((state_q == FS_IDLE) ||
                               ((state_q == FS_DONE) && inst_ready));
    mem_rd_en     = w_issue;
    mem_addr      = w_issue ? w_addr_sum[63:0] : 64'd0;
    inst_valid    = (state_q == FS_DONE);
    inst_bytes    = bytes_q;
    inst_len      = len_q;
    valP          = pc_q + {60'd0, len_q};
    imem_error    = err_q;
    instr_invalid = inv_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer -- directed self-checking bench for fetch_sequencer.
// Rev 1.0
`default_nettype none

module tb_fetch_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  pc_in;
  logic         pc_valid;
  logic         pc_ready;
  logic         mem_rd_en;
  logic [63:0]  mem_addr;
  logic [7:0]   mem_rdata = 8'h00;
  logic [79:0]  inst_bytes;
  logic [3:0]   inst_len;
  logic [63:0]  valP;
  logic         imem_error;
  logic         instr_invalid;
  logic         inst_valid;
  logic         inst_ready;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .MEM_LAST_ADDR (64'd200),
    .MAX_LEN       (10)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_in         (pc_in),
    .pc_valid      (pc_valid),
    .pc_ready      (pc_ready),
    .mem_rd_en     (mem_rd_en),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .inst_bytes    (inst_bytes),
    .inst_len      (inst_len),
    .valP          (valP),
    .imem_error    (imem_error),
    .instr_invalid (instr_invalid),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready)
  );

  logic [7:0]  mem [0:255];
  int          cyc = 0;
  logic [63:0] rd_addr [$];
  int          rd_cyc  [$];

  // Synchronous-read memory; also logs every read with the cycle it was issued in.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_en) begin
      mem_rdata <= mem[mem_addr[7:0]];
      rd_addr.push_back(mem_addr);
      rd_cyc.push_back(cyc);
    end
  end

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic run_fetch(input string tag, input logic [63:0] pc, input logic b2b,
                           input logic [3:0] elen, input logic [79:0] ebytes,
                           input logic eerr, input logic einv,
                           input int elat, input int nreads);
    int c0;
    int base;
    int lat;
    bit seen;
    @(negedge clk);
    pc_in      = pc;
    pc_valid   = 1'b1;
    inst_ready = b2b;
    #1;
    check({tag, "/pc_ready"}, 128'(pc_ready), 128'(1));
    c0   = cyc;
    base = rd_addr.size();
    @(negedge clk);
    pc_valid   = 1'b0;
    inst_ready = 1'b0;
    #1;
    check({tag, "/rd0_en"}, 128'(mem_rd_en), 128'(nreads > 0));
    check({tag, "/rd0_addr"}, 128'(mem_addr), (nreads > 0) ? 128'(pc) : 128'(0));
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (inst_valid) seen = 1'b1;
      else @(negedge clk);
    end
    lat = cyc - c0;
    check({tag, "/valid"}, 128'(seen), 128'(1));
    check({tag, "/latency"}, 128'(lat), 128'(elat));
    check({tag, "/len"}, 128'(inst_len), 128'(elen));
    check({tag, "/bytes"}, 128'(inst_bytes), 128'(ebytes));
    check({tag, "/valP"}, 128'(valP), 128'(pc + 64'(elen)));
    check({tag, "/imem_error"}, 128'(imem_error), 128'(eerr));
    check({tag, "/invalid"}, 128'(instr_invalid), 128'(einv));
    check({tag, "/pc_ready_done"}, 128'(pc_ready), 128'(0));
    check({tag, "/nreads"}, 128'(rd_addr.size() - base), 128'(nreads));
    for (int i = 0; i < nreads && (base + i) < rd_addr.size(); i++) begin
      check({tag, "/rd_addr"}, 128'(rd_addr[base+i]), 128'(pc + 64'(i)));
      check({tag, "/rd_cyc"}, 128'(rd_cyc[base+i]), 128'(c0 + 1 + i));
    end
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    inst_ready = 1'b1;
    #1;
    check({tag, "/hs_pc_ready"}, 128'(pc_ready), 128'(1));
    @(negedge clk);
    inst_ready = 1'b0;
    #1;
    check({tag, "/idle_valid"}, 128'(inst_valid), 128'(0));
    check({tag, "/idle_pc_ready"}, 128'(pc_ready), 128'(1));
    check({tag, "/idle_flags"}, 128'({imem_error, instr_invalid}), 128'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/pc_ready"}, 128'(pc_ready), 128'(0));
    check({tag, "/rd_en"}, 128'(mem_rd_en), 128'(0));
    check({tag, "/addr"}, 128'(mem_addr), 128'(0));
    check({tag, "/bytes"}, 128'(inst_bytes), 128'(0));
    check({tag, "/len_valP"}, {60'd0, inst_len, valP}, 128'(0));
    check({tag, "/flags"}, 128'({imem_error, instr_invalid, inst_valid}), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
    mem[0]    = 8'h10;
    mem[4]    = 8'hC0;
    mem[8'h10] = 8'h30; mem[8'h11] = 8'hF2; mem[8'h12] = 8'h0A;
    for (int i = 8'h13; i <= 8'h19; i++) mem[i] = 8'h00;
    mem[8'h20] = 8'h20; mem[8'h21] = 8'h01;
    mem[8'h22] = 8'h20; mem[8'h23] = 8'h23;
    mem[195] = 8'h30; mem[196] = 8'hF3; mem[197] = 8'h11;
    mem[198] = 8'h22; mem[199] = 8'h33; mem[200] = 8'h44;

    reset      = 1'b1;
    pc_in      = 64'd0;
    pc_valid   = 1'b0;
    inst_ready = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset/pc_ready_after", 128'(pc_ready), 128'(1));

    run_fetch("nop", 64'd0, 1'b0, 4'd1, 80'h10, 1'b0, 1'b0, 3, 1);
    handshake("nop");

    run_fetch("irmovq", 64'h10, 1'b0, 4'd10, 80'h0000_0000_0000_000A_F230, 1'b0, 1'b0, 12, 10);
    handshake("irmovq");

    run_fetch("rr1", 64'h20, 1'b0, 4'd2, 80'h0120, 1'b0, 1'b0, 4, 2);
    run_fetch("rr2", 64'h22, 1'b1, 4'd2, 80'h2320, 1'b0, 1'b0, 4, 2);
    handshake("rr2");

    run_fetch("edge", 64'd195, 1'b0, 4'd10, 80'h0000_0000_4433_2211_F330, 1'b1, 1'b0, 8, 6);
    handshake("edge");

    run_fetch("inv", 64'd4, 1'b0, 4'd1, 80'hC0, 1'b0, 1'b1, 3, 1);
    handshake("inv");

    run_fetch("oor", 64'd201, 1'b0, 4'd0, 80'h0, 1'b1, 1'b0, 2, 0);
    handshake("oor");

    // Hold decode off for five cycles: outputs frozen, no reads.
    run_fetch("stall", 64'h20, 1'b0, 4'd2, 80'h0120, 1'b0, 1'b0, 4, 2);
    base = rd_addr.size();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall/valid", 128'(inst_valid), 128'(1));
      check("stall/bytes", 128'(inst_bytes), 128'(80'h0120));
      check("stall/len_valP", {60'd0, inst_len, valP}, {60'd0, 4'd2, 64'h22});
      check("stall/no_reads", 128'(rd_addr.size() - base), 128'(0));
    end
    handshake("stall");

    // Reset in the middle of an irmovq fetch.
    @(negedge clk);
    pc_in    = 64'h10;
    pc_valid = 1'b1;
    @(negedge clk);
    pc_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst/reading", 128'(mem_rd_en), 128'(1));
    reset = 1'b1;
    #1;
    check_all_zero("midrst");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst/pc_ready_after", 128'(pc_ready), 128'(1));
    run_fetch("nop2", 64'd0, 1'b0, 4'd1, 80'h10, 1'b0, 1'b0, 3, 1);
    handshake("nop2");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
